// File: rtl/booth_mult_seq_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_mult_seq_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth recoding of {q[0], q_1}; the other two codes leave acc untouched.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/done request bus between the ALU decode (master) and the multiplier (slave).
interface booth_mult_seq_if
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  // Handshake: start is only looked at while busy=0; the rising edge that sees
  // start=1 in IDLE captures a and b. done is a one-cycle pulse, p holds after it.
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/booth_mult_seq_step.sv
// One radix-2 Booth step: conditional add/subtract of m into acc, then arithmetic shift right.
module booth_mult_seq_step
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH+1:0] work,
  input  logic [WIDTH:0]     m,
  output logic [2*WIDTH+1:0] work_next
);

  logic [WIDTH:0] acc;
  logic [WIDTH:0] sum;

  always_comb begin
    acc = work[2*WIDTH+1:WIDTH+1];
    sum = acc;
    // Sums wrap at WIDTH+1 bits; the carry out is meaningless here.
    case (work[1:0])
      BOOTH_ADD: sum = acc + m;
      BOOTH_SUB: sum = acc - m;
      default:   sum = acc;
    endcase
    work_next = {sum[WIDTH], sum, work[WIDTH:1]};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier: one Booth step per clock, start/done handshake.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  booth_mult_seq_if.slave  bus,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [WIDTH:0]      m;
  logic [2*WIDTH+1:0]  work;
  logic [2*WIDTH+1:0]  work_next;
  logic                busy_r;
  logic                done_r;
  logic [2*WIDTH-1:0]  p_r;

  booth_mult_seq_step #(.WIDTH(WIDTH)) u_step (
    .work      (work),
    .m         (m),
    .work_next (work_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      m      <= '0;
      work   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      p_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            work   <= {{(WIDTH+1){1'b0}}, bus.b, 1'b0};
            m      <= {bus.a[WIDTH-1], bus.a};
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          work <= work_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            // acc[WIDTH] is a redundant sign copy once all steps are done.
            p_r    <= work_next[2*WIDTH:1];
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.p     = p_r;
  assign dbg_state = state;

endmodule
